// File: rtl/keypad_debounce.sv
// Keypad conditioner: 2-flop synchroniser, per-key debounce FSM, single-cycle press pulses
// with optional auto-repeat, and registered debounced levels.
module keypad_debounce #(
  parameter int unsigned NKEYS           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter bit          REPEAT_EN       = 1'b1,
  parameter int unsigned REPEAT_DELAY    = 12500000,
  parameter int unsigned REPEAT_RATE     = 2500000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NKEYS-1:0] keys_raw,
  output logic [NKEYS-1:0] keypad,
  output logic [NKEYS-1:0] key_level,
  output logic             any_key
);

  localparam int unsigned DMAX = DEBOUNCE_CYCLES - 1;
  localparam int unsigned RMAX = ((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE) - 1;
  localparam int unsigned DW   = (DMAX > 0) ? $clog2(DMAX + 1) : 1;
  localparam int unsigned RW   = (RMAX > 0) ? $clog2(RMAX + 1) : 1;

  localparam logic [DW-1:0] DTERM  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RDELAY = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RRATE  = RW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {StIdle, StDebPress, StHeld, StDebRelease} state_e;

  logic [NKEYS-1:0] sync_q, s_q;
  logic [NKEYS-1:0] pulse_d, level_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= '0;
      s_q    <= '0;
    end else begin
      sync_q <= keys_raw;
      s_q    <= sync_q;
    end
  end

  for (genvar i = 0; i < NKEYS; i++) begin : g_key
    state_e          state_q, state_d;
    logic [DW-1:0]   dcnt_q, dcnt_d;
    logic [RW-1:0]   rcnt_q, rcnt_d;
    logic            rep_q, rep_d;  // first repeat already issued in this hold
    logic            accept, repeat_hit;
    logic            pulse, level;

    assign accept     = (state_q == StDebPress) && s_q[i] && (dcnt_q == DTERM);
    assign repeat_hit = (state_q == StHeld) && s_q[i] && REPEAT_EN &&
                        (rcnt_q == (rep_q ? RRATE : RDELAY));

    always_ff @(posedge clk) begin
      if (!rst) begin
        state_q <= StIdle;
        dcnt_q  <= '0;
        rcnt_q  <= '0;
        rep_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        dcnt_q  <= dcnt_d;
        rcnt_q  <= rcnt_d;
        rep_q   <= rep_d;
      end
    end

    always_comb begin
      state_d = state_q;
      dcnt_d  = dcnt_q;
      rcnt_d  = rcnt_q;
      rep_d   = rep_q;
      unique case (state_q)
        StIdle: begin
          if (s_q[i]) begin
            state_d = StDebPress;
            dcnt_d  = '0;
          end
        end
        StDebPress: begin
          if (!s_q[i]) begin
            state_d = StIdle;
          end else if (accept) begin
            state_d = StHeld;
            rcnt_d  = '0;
            rep_d   = 1'b0;
          end else begin
            dcnt_d = dcnt_q + 1'b1;
          end
        end
        StHeld: begin
          if (!s_q[i]) begin
            state_d = StDebRelease;
            dcnt_d  = '0;
          end else if (REPEAT_EN) begin
            if (repeat_hit) begin
              rcnt_d = '0;
              rep_d  = 1'b1;
            end else begin
              rcnt_d = rcnt_q + 1'b1;
            end
          end
        end
        StDebRelease: begin
          // A bounce back high resumes the hold with the repeat timer untouched
          if (s_q[i]) begin
            state_d = StHeld;
          end else if (dcnt_q == DTERM) begin
            state_d = StIdle;
          end else begin
            dcnt_d = dcnt_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    always_comb begin
      pulse = accept | repeat_hit;
      level = (state_d == StHeld) || (state_d == StDebRelease);
    end

    assign pulse_d[i] = pulse;
    assign level_d[i] = level;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      keypad    <= '0;
      key_level <= '0;
      any_key   <= 1'b0;
    end else begin
      keypad    <= pulse_d;
      key_level <= level_d;
      any_key   <= |level_d;
    end
  end

endmodule

// File: tb/tb_keypad_debounce.sv
// Bench for keypad_debounce: constant-vector tables and directed sequences, plus random bouncy
// stimulus checked every cycle against a run-length/hold-tick reference model.
module tb_keypad_debounce;

  localparam int DEB = 4;
  localparam int RD  = 10;
  localparam int RR  = 3;

  logic       clk;
  logic       rst;
  logic [7:0] keys_raw;
  logic [7:0] kp0, lvl0, kp1, lvl1;
  logic       any0, any1;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  keypad_debounce #(
    .NKEYS(8), .DEBOUNCE_CYCLES(DEB), .REPEAT_EN(1'b1), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk(clk), .rst(rst), .keys_raw(keys_raw), .keypad(kp0), .key_level(lvl0), .any_key(any0)
  );

  keypad_debounce #(
    .NKEYS(8), .DEBOUNCE_CYCLES(DEB), .REPEAT_EN(1'b0), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut_nr (
    .clk(clk), .rst(rst), .keys_raw(keys_raw), .keypad(kp1), .key_level(lvl1), .any_key(any1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a level flips once the synchronised input has disagreed with it for
  // DEB+1 consecutive edges; while held, qualifying hold ticks are counted against the interval.
  logic [7:0] m_f1 [2];
  logic [7:0] m_f2 [2];
  logic [7:0] m_lvl [2];
  logic [7:0] m_prev [2];
  logic [7:0] m_pulse [2];
  int         m_run [2][8];
  int         m_ticks [2][8];
  int         m_ival [2][8];
  logic [7:0] prev_kp [2];

  task automatic model_step(input logic [7:0] raw, input logic rv);
    logic [7:0] s;
    for (int m = 0; m < 2; m++) begin
      m_pulse[m] = 8'h00;
      if (!rv) begin
        m_f1[m] = 8'h00; m_f2[m] = 8'h00; m_lvl[m] = 8'h00; m_prev[m] = 8'h00;
        for (int k = 0; k < 8; k++) begin
          m_run[m][k] = 0; m_ticks[m][k] = 0; m_ival[m][k] = RD;
        end
      end else begin
        s = m_f2[m];
        m_f2[m] = m_f1[m];
        m_f1[m] = raw;
        for (int k = 0; k < 8; k++) begin
          if (s[k] != m_lvl[m][k]) begin
            m_run[m][k]++;
            if (m_run[m][k] == DEB + 1) begin
              m_lvl[m][k] = s[k];
              m_run[m][k] = 0;
              if (s[k]) begin
                m_pulse[m][k] = 1'b1;
                m_ticks[m][k] = 0;
                m_ival[m][k]  = RD;
              end
            end
          end else begin
            m_run[m][k] = 0;
            if (m == 0 && m_lvl[m][k] && m_prev[m][k]) begin
              m_ticks[m][k]++;
              if (m_ticks[m][k] == m_ival[m][k]) begin
                m_pulse[m][k] = 1'b1;
                m_ticks[m][k] = 0;
                m_ival[m][k]  = RR;
              end
            end
          end
        end
        m_prev[m] = s;
      end
    end
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Apply one cycle of inputs, let the edge happen, then compare at the falling edge.
  task automatic tick(input logic [7:0] raw, input logic rv);
    logic [7:0] kp [2];
    logic [7:0] lv [2];
    logic       an [2];
    keys_raw = raw;
    rst      = rv;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    model_step(raw, rv);
    kp[0] = kp0; lv[0] = lvl0; an[0] = any0;
    kp[1] = kp1; lv[1] = lvl1; an[1] = any1;
    for (int m = 0; m < 2; m++) begin
      check(m == 0 ? "model keypad" : "model keypad nr", kp[m], m_pulse[m]);
      check(m == 0 ? "model level" : "model level nr", lv[m], m_lvl[m]);
      check(m == 0 ? "model any" : "model any nr", {7'd0, an[m]}, {7'd0, |m_lvl[m]});
      check(m == 0 ? "pulse twice" : "pulse twice nr", kp[m] & prev_kp[m], 8'h00);
      check(m == 0 ? "pulse no level" : "pulse no level nr", kp[m] & ~lv[m], 8'h00);
      prev_kp[m] = kp[m];
    end
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) tick(8'h00, 1'b1);
  endtask

  typedef struct {
    logic [7:0] raw;
    logic [7:0] kp;
    logic [7:0] kp_nr;
    logic [7:0] lvl;
  } vec_t;

  vec_t       tbl [30];
  logic [7:0] r;
  logic [7:0] seen;
  int         npulse;

  initial begin
    prev_kp[0] = 8'h00;
    prev_kp[1] = 8'h00;
    keys_raw   = 8'h00;
    rst        = 1'b0;
    @(negedge clk);

    // Reset state
    for (int i = 0; i < 3; i++) begin
      tick(8'h00, 1'b0);
      check("reset keypad", kp0, 8'h00);
      check("reset level", lvl0, 8'h00);
      check("reset any", {7'd0, any0}, 8'h00);
    end
    settle(4);

    // 1. Clean press of key 0 held 30 cycles
    for (int t = 0; t < 30; t++) begin
      tbl[t].raw   = 8'h01;
      tbl[t].kp    = (t == 6 || t == 16 || t == 19 || t == 22 || t == 25 || t == 28) ? 8'h01 : 8'h00;
      tbl[t].kp_nr = (t == 6) ? 8'h01 : 8'h00;
      tbl[t].lvl   = (t >= 6) ? 8'h01 : 8'h00;
    end
    for (int t = 0; t < 30; t++) begin
      tick(tbl[t].raw, 1'b1);
      check("t1 keypad", kp0, tbl[t].kp);
      check("t1 keypad nr", kp1, tbl[t].kp_nr);
      check("t1 level", lvl0, tbl[t].lvl);
    end
    settle(10);

    // 2. Bounce on key 2 never accepted
    seen = 8'h00;
    for (int t = 0; t < 14; t++) begin
      tick((t < 4 && (t % 2 == 0)) ? 8'h04 : 8'h00, 1'b1);
      seen = seen | kp0 | lvl0 | kp1 | lvl1;
    end
    check("t2 bounce outputs", seen, 8'h00);

    // 3. Release glitch on key 3
    for (int t = 0; t < 20; t++) begin
      tick((t == 10 || t == 11) ? 8'h00 : 8'h08, 1'b1);
      check("t3 level", lvl0 & 8'h08, (t >= 6) ? 8'h08 : 8'h00);
      check("t3 keypad nr", kp1, (t == 6) ? 8'h08 : 8'h00);
    end
    for (int t = 0; t < 10; t++) begin
      tick(8'h00, 1'b1);
      check("t3 release level", lvl0, (t < 6) ? 8'h08 : 8'h00);
      check("t3 release level nr", lvl1, (t < 6) ? 8'h08 : 8'h00);
    end
    settle(4);

    // 4. Simultaneous press of keys 0 and 7, no repeat
    npulse = 0;
    for (int t = 0; t < 30; t++) begin
      tick(8'h81, 1'b1);
      if (kp1 != 8'h00) npulse++;
      if (t == 6) check("t4 keypad nr", kp1, 8'h81);
      if (t == 6) check("t4 any nr", {7'd0, any1}, 8'h01);
    end
    check("t4 pulse count nr", 8'(npulse), 8'd1);
    settle(10);

    // 5. Reset mid-debounce and mid-hold with key held
    for (int t = 0; t < 3; t++) tick(8'h01, 1'b1);
    tick(8'h01, 1'b0);
    check("t5a level", lvl0 | lvl1, 8'h00);
    check("t5a keypad", kp0 | kp1, 8'h00);
    check("t5a any", {7'd0, any0 | any1}, 8'h00);
    for (int t = 0; t < 10; t++) begin
      tick(8'h01, 1'b1);
      check("t5a repress", kp0, (t == 6) ? 8'h01 : 8'h00);
      check("t5a repress nr", kp1, (t == 6) ? 8'h01 : 8'h00);
    end
    tick(8'h01, 1'b0);
    check("t5b level", lvl0 | lvl1, 8'h00);
    check("t5b keypad", kp0 | kp1, 8'h00);
    check("t5b any", {7'd0, any0 | any1}, 8'h00);
    for (int t = 0; t < 9; t++) begin
      tick(8'h01, 1'b1);
      check("t5b repress", kp0, (t == 6) ? 8'h01 : 8'h00);
      check("t5b level", lvl0, (t >= 6) ? 8'h01 : 8'h00);
    end
    settle(10);

    // 6. Random bouncy stimulus with occasional reset
    r = 8'h00;
    for (int t = 0; t < 1500; t++) begin
      if ($urandom_range(0, 3) == 0) r = r ^ (8'h01 << $urandom_range(0, 7));
      tick(r, ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
